// File: rtl/branch_resolver_if.sv
// rtl/branch_resolver_if.sv - issue, comparator and redirect signals of the branch resolver
interface branch_resolver_if #(
    parameter int XLEN          = 32,
    parameter int CMP_SEL_WIDTH = 2
);
    logic                     i_Flush;
    logic                     i_Branch_Valid;
    logic                     o_Branch_Ready;
    logic [2:0]               i_Funct3;
    logic [XLEN-1:0]          i_Rs1_Data;
    logic [XLEN-1:0]          i_Rs2_Data;
    logic [XLEN-1:0]          i_Pc;
    logic [XLEN-1:0]          i_Imm;
    logic                     i_Predicted_Taken;
    logic                     o_Cmp_Enable;
    logic [XLEN-1:0]          o_Cmp_A;
    logic [XLEN-1:0]          o_Cmp_B;
    logic [CMP_SEL_WIDTH:0]   o_Cmp_Select;
    logic                     i_Cmp_Result;
    logic                     o_Redirect_Valid;
    logic                     i_Redirect_Ready;
    logic [XLEN-1:0]          o_Redirect_Pc;
    logic                     o_Resolve_Valid;
    logic                     o_Resolve_Taken;
    logic                     o_Misaligned;
    logic                     o_Illegal;

    modport master (
        input  i_Flush, i_Branch_Valid, i_Funct3, i_Rs1_Data, i_Rs2_Data, i_Pc, i_Imm,
               i_Predicted_Taken, i_Cmp_Result, i_Redirect_Ready,
        output o_Branch_Ready, o_Cmp_Enable, o_Cmp_A, o_Cmp_B, o_Cmp_Select,
               o_Redirect_Valid, o_Redirect_Pc, o_Resolve_Valid, o_Resolve_Taken,
               o_Misaligned, o_Illegal
    );

    modport slave (
        output i_Flush, i_Branch_Valid, i_Funct3, i_Rs1_Data, i_Rs2_Data, i_Pc, i_Imm,
               i_Predicted_Taken, i_Cmp_Result, i_Redirect_Ready,
        input  o_Branch_Ready, o_Cmp_Enable, o_Cmp_A, o_Cmp_B, o_Cmp_Select,
               o_Redirect_Valid, o_Redirect_Pc, o_Resolve_Valid, o_Resolve_Taken,
               o_Misaligned, o_Illegal
    );
endinterface

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - conditional branch resolver driving the comparator and fetch redirect
// Optional branch/mispredict counters enabled by BRANCH_RESOLVER_STATS_EN.
module branch_resolver #(
    parameter int XLEN          = 32,
    parameter int CMP_SEL_WIDTH = 2
) (
    input  logic i_Clock,
    input  logic i_Reset_N,
    branch_resolver_if.master bus
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [31:0] o_Branch_Count,
    output logic [31:0] o_Mispredict_Count
`endif
);
    localparam logic [CMP_SEL_WIDTH:0] SEL_EQ  = (CMP_SEL_WIDTH+1)'(0);
    localparam logic [CMP_SEL_WIDTH:0] SEL_NE  = (CMP_SEL_WIDTH+1)'(1);
    localparam logic [CMP_SEL_WIDTH:0] SEL_LT  = (CMP_SEL_WIDTH+1)'(2);
    localparam logic [CMP_SEL_WIDTH:0] SEL_GE  = (CMP_SEL_WIDTH+1)'(3);
    localparam logic [CMP_SEL_WIDTH:0] SEL_LTU = (CMP_SEL_WIDTH+1)'(4);
    localparam logic [CMP_SEL_WIDTH:0] SEL_GEU = (CMP_SEL_WIDTH+1)'(5);

    typedef enum logic [1:0] {IDLE, EVAL, RESOLVE, REDIRECT} state_t;

    state_t          state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;
    logic            pred_q;
    logic            illegal_q;
    logic            taken_q;
    logic            resolve_q;
    logic            misaligned_q;
    logic            illegal_pulse_q;

    logic            cmp_taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] fallthrough;
    logic            handshake;

    function automatic logic [CMP_SEL_WIDTH:0] sel_of(input logic [2:0] f3);
        case (f3)
            3'b001:  sel_of = SEL_NE;
            3'b100:  sel_of = SEL_LT;
            3'b101:  sel_of = SEL_GE;
            3'b110:  sel_of = SEL_LTU;
            3'b111:  sel_of = SEL_GEU;
            default: sel_of = SEL_EQ;
        endcase
    endfunction

    assign cmp_taken   = bus.i_Cmp_Result & ~illegal_q;
    assign target      = pc_q + imm_q;
    assign fallthrough = pc_q + XLEN'(4);
    // The redirect retires in its handshake cycle; a concurrent flush cancels it.
    assign handshake   = (state == REDIRECT) & bus.o_Redirect_Valid & bus.i_Redirect_Ready & ~bus.i_Flush;

    assign bus.o_Resolve_Valid = (resolve_q & ~bus.i_Flush) | handshake;
    assign bus.o_Resolve_Taken = bus.o_Resolve_Valid & taken_q;
    assign bus.o_Misaligned    = misaligned_q & ~bus.i_Flush;
    assign bus.o_Illegal       = illegal_pulse_q & ~bus.i_Flush;

    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            state                <= IDLE;
            pc_q                 <= '0;
            imm_q                <= '0;
            pred_q               <= 1'b0;
            illegal_q            <= 1'b0;
            taken_q              <= 1'b0;
            resolve_q            <= 1'b0;
            misaligned_q         <= 1'b0;
            illegal_pulse_q      <= 1'b0;
            bus.o_Branch_Ready   <= 1'b1;
            bus.o_Cmp_Enable     <= 1'b0;
            bus.o_Cmp_A          <= '0;
            bus.o_Cmp_B          <= '0;
            bus.o_Cmp_Select     <= '0;
            bus.o_Redirect_Valid <= 1'b0;
            bus.o_Redirect_Pc    <= '0;
        end else begin
            resolve_q        <= 1'b0;
            misaligned_q     <= 1'b0;
            illegal_pulse_q  <= 1'b0;
            bus.o_Cmp_Enable <= 1'b0;
            bus.o_Cmp_A      <= '0;
            bus.o_Cmp_B      <= '0;
            bus.o_Cmp_Select <= '0;
            if (bus.i_Flush) begin
                state                <= IDLE;
                bus.o_Branch_Ready   <= 1'b1;
                bus.o_Redirect_Valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (bus.i_Branch_Valid) begin
                        pc_q               <= bus.i_Pc;
                        imm_q              <= bus.i_Imm;
                        pred_q             <= bus.i_Predicted_Taken;
                        illegal_q          <= (bus.i_Funct3[2:1] == 2'b01);
                        bus.o_Cmp_Enable   <= 1'b1;
                        bus.o_Cmp_A        <= bus.i_Rs1_Data;
                        bus.o_Cmp_B        <= bus.i_Rs2_Data;
                        bus.o_Cmp_Select   <= sel_of(bus.i_Funct3);
                        bus.o_Branch_Ready <= 1'b0;
                        state              <= EVAL;
                    end
                    EVAL: begin
                        // Decide the outcome now so resolve/redirect is visible one cycle later.
                        taken_q <= cmp_taken;
                        if (illegal_q) begin
                            illegal_pulse_q <= 1'b1;
                            resolve_q       <= 1'b1;
                            state           <= RESOLVE;
                        end else if (cmp_taken && target[1:0] != 2'b00) begin
                            misaligned_q <= 1'b1;
                            resolve_q    <= 1'b1;
                            state        <= RESOLVE;
                        end else if (cmp_taken == pred_q) begin
                            resolve_q <= 1'b1;
                            state     <= RESOLVE;
                        end else begin
                            bus.o_Redirect_Valid <= 1'b1;
                            bus.o_Redirect_Pc    <= cmp_taken ? target : fallthrough;
                            state                <= REDIRECT;
                        end
                    end
                    RESOLVE: begin
                        bus.o_Branch_Ready <= 1'b1;
                        state              <= IDLE;
                    end
                    REDIRECT: if (bus.i_Redirect_Ready) begin
                        bus.o_Redirect_Valid <= 1'b0;
                        bus.o_Branch_Ready   <= 1'b1;
                        state                <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            o_Branch_Count     <= '0;
            o_Mispredict_Count <= '0;
        end else begin
            if (bus.o_Resolve_Valid && o_Branch_Count != 32'hFFFF_FFFF)
                o_Branch_Count <= o_Branch_Count + 32'd1;
            if (handshake && o_Mispredict_Count != 32'hFFFF_FFFF)
                o_Mispredict_Count <= o_Mispredict_Count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - self-checking bench for branch_resolver
module tb_branch_resolver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   exp_branches = 0;
    int   exp_mispredicts = 0;

    always #5 clk = ~clk;

    branch_resolver_if #(.XLEN(32), .CMP_SEL_WIDTH(2)) bus ();

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
    branch_resolver dut (.i_Clock(clk), .i_Reset_N(rst_n), .bus(bus),
                         .o_Branch_Count(branch_count), .o_Mispredict_Count(mispredict_count));
`else
    branch_resolver dut (.i_Clock(clk), .i_Reset_N(rst_n), .bus(bus));
`endif

    // External comparator: EQ=0 NE=1 LT=2 GE=3 LTU=4 GEU=5
    always_comb begin
        case (bus.o_Cmp_Select)
            3'd0:    bus.i_Cmp_Result = (bus.o_Cmp_A == bus.o_Cmp_B);
            3'd1:    bus.i_Cmp_Result = (bus.o_Cmp_A != bus.o_Cmp_B);
            3'd2:    bus.i_Cmp_Result = ($signed(bus.o_Cmp_A) < $signed(bus.o_Cmp_B));
            3'd3:    bus.i_Cmp_Result = ($signed(bus.o_Cmp_A) >= $signed(bus.o_Cmp_B));
            3'd4:    bus.i_Cmp_Result = (bus.o_Cmp_A < bus.o_Cmp_B);
            3'd5:    bus.i_Cmp_Result = (bus.o_Cmp_A >= bus.o_Cmp_B);
            default: bus.i_Cmp_Result = 1'b0;
        endcase
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a, b, pc, imm;
        logic        pred, ill, tk, mis, redir;
        logic [31:0] rpc;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [31:0] sel_exp(input logic [2:0] f3);
        case (f3)
            3'b001:  return 32'd1;
            3'b100:  return 32'd2;
            3'b101:  return 32'd3;
            3'b110:  return 32'd4;
            3'b111:  return 32'd5;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference outcome from the ISA rules, independent of any state machine.
    task automatic model(inout vec_t v);
        logic [31:0] tgt;
        v.ill = (v.f3 == 3'b010) || (v.f3 == 3'b011);
        case (v.f3)
            3'b000:  v.tk = (v.a == v.b);
            3'b001:  v.tk = (v.a != v.b);
            3'b100:  v.tk = ($signed(v.a) < $signed(v.b));
            3'b101:  v.tk = ($signed(v.a) >= $signed(v.b));
            3'b110:  v.tk = (v.a < v.b);
            3'b111:  v.tk = (v.a >= v.b);
            default: v.tk = 1'b0;
        endcase
        tgt     = v.pc + v.imm;
        v.mis   = v.tk && (tgt[1:0] != 2'b00);
        v.redir = !v.ill && !v.mis && (v.tk != v.pred);
        v.rpc   = v.redir ? (v.tk ? tgt : v.pc + 32'd4) : 32'd0;
    endtask

    task automatic offer(input vec_t v);
        bus.i_Funct3          = v.f3;
        bus.i_Rs1_Data        = v.a;
        bus.i_Rs2_Data        = v.b;
        bus.i_Pc              = v.pc;
        bus.i_Imm             = v.imm;
        bus.i_Predicted_Taken = v.pred;
        bus.i_Branch_Valid    = 1'b1;
    endtask

    task automatic run(input vec_t v, input int dly, input string tag);
        for (int k = 0; k < 20 && !bus.o_Branch_Ready; k++) @(negedge clk);
        chk({tag, "_ready"}, 32'(bus.o_Branch_Ready), 32'd1);
        offer(v);
        @(negedge clk);
        bus.i_Branch_Valid = 1'b0;
        chk({tag, "_cmp_en"}, 32'(bus.o_Cmp_Enable), 32'd1);
        chk({tag, "_cmp_sel"}, 32'(bus.o_Cmp_Select), sel_exp(v.f3));
        chk({tag, "_cmp_a"}, bus.o_Cmp_A, v.a);
        chk({tag, "_cmp_b"}, bus.o_Cmp_B, v.b);
        @(negedge clk);
        chk({tag, "_cmp_off"}, 32'(bus.o_Cmp_Enable), 32'd0);
        chk({tag, "_redir_valid"}, 32'(bus.o_Redirect_Valid), 32'(v.redir));
        if (!v.redir) begin
            chk({tag, "_resolve"}, 32'(bus.o_Resolve_Valid), 32'd1);
            chk({tag, "_taken"}, 32'(bus.o_Resolve_Taken), 32'(v.tk && !v.ill));
            chk({tag, "_misaligned"}, 32'(bus.o_Misaligned), 32'(v.mis));
            chk({tag, "_illegal"}, 32'(bus.o_Illegal), 32'(v.ill));
            exp_branches++;
        end else begin
            chk({tag, "_redir_pc"}, bus.o_Redirect_Pc, v.rpc);
            chk({tag, "_no_early_resolve"}, 32'(bus.o_Resolve_Valid), 32'd0);
            for (int k = 0; k < dly; k++) begin
                @(negedge clk);
                chk({tag, "_hold_valid"}, 32'(bus.o_Redirect_Valid), 32'd1);
                chk({tag, "_hold_pc"}, bus.o_Redirect_Pc, v.rpc);
                chk({tag, "_hold_no_resolve"}, 32'(bus.o_Resolve_Valid), 32'd0);
            end
            bus.i_Redirect_Ready = 1'b1;
            #1;
            chk({tag, "_hs_resolve"}, 32'(bus.o_Resolve_Valid), 32'd1);
            chk({tag, "_hs_taken"}, 32'(bus.o_Resolve_Taken), 32'(v.tk));
            exp_branches++;
            exp_mispredicts++;
        end
        @(negedge clk);
        bus.i_Redirect_Ready = 1'b0;
        chk({tag, "_after_redir"}, 32'(bus.o_Redirect_Valid), 32'd0);
        chk({tag, "_after_resolve"}, 32'(bus.o_Resolve_Valid), 32'd0);
        chk({tag, "_after_ready"}, 32'(bus.o_Branch_Ready), 32'd1);
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h120};
        tbl[1] = '{3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[2] = '{3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h104};
        tbl[3] = '{3'b001, 32'h1, 32'h2, 32'h200, 32'h6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[4] = '{3'b001, 32'h3, 32'h3, 32'h200, 32'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[5] = '{3'b010, 32'h7, 32'h7, 32'h300, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[6] = '{3'b000, 32'h9, 32'h9, 32'hFFFF_FFFC, 32'h8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4};
        tbl[7] = '{3'b101, 32'hFFFF_FFFB, 32'h3, 32'h400, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[8] = '{3'b111, 32'h8000_0000, 32'h3, 32'h300, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h310};
        tbl[9] = '{3'b011, 32'h1, 32'h2, 32'h500, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

        bus.i_Flush = 1'b0; bus.i_Branch_Valid = 1'b0; bus.i_Redirect_Ready = 1'b0;
        bus.i_Funct3 = '0; bus.i_Rs1_Data = '0; bus.i_Rs2_Data = '0;
        bus.i_Pc = '0; bus.i_Imm = '0; bus.i_Predicted_Taken = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.o_Branch_Ready), 32'd1);
        chk("rst_cmp_en", 32'(bus.o_Cmp_Enable), 32'd0);
        chk("rst_redir", 32'(bus.o_Redirect_Valid), 32'd0);
        chk("rst_resolve", 32'(bus.o_Resolve_Valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run(tbl[i], (i == 0) ? 3 : i % 3, $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            v.f3   = 3'($urandom_range(0, 7));
            v.a    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            v.b    = ($urandom_range(0, 2) == 0) ? v.a : $urandom;
            v.pc   = $urandom & 32'hFFFF_FFFC;
            v.imm  = $urandom & 32'h0000_0FFE;
            if ($urandom_range(0, 1) == 1) v.imm = -v.imm;
            v.pred = 1'($urandom_range(0, 1));
            model(v);
            run(v, $urandom_range(0, 2), $sformatf("rnd%0d", i));
        end

        // Flush on the redirect handshake cycle wins.
        offer(tbl[0]);
        @(negedge clk); bus.i_Branch_Valid = 1'b0;
        @(negedge clk);
        chk("flush_redir_pre", 32'(bus.o_Redirect_Valid), 32'd1);
        bus.i_Flush = 1'b1; bus.i_Redirect_Ready = 1'b1;
        #1 chk("flush_redir_no_resolve", 32'(bus.o_Resolve_Valid), 32'd0);
        @(negedge clk); bus.i_Flush = 1'b0; bus.i_Redirect_Ready = 1'b0;
        chk("flush_redir_valid", 32'(bus.o_Redirect_Valid), 32'd0);
        chk("flush_redir_ready", 32'(bus.o_Branch_Ready), 32'd1);
        chk("flush_redir_resolve", 32'(bus.o_Resolve_Valid), 32'd0);

        // Flush alongside an offer: nothing is accepted.
        offer(tbl[1]); bus.i_Flush = 1'b1;
        @(negedge clk); bus.i_Branch_Valid = 1'b0; bus.i_Flush = 1'b0;
        chk("flush_offer_cmp_en", 32'(bus.o_Cmp_Enable), 32'd0);
        chk("flush_offer_ready", 32'(bus.o_Branch_Ready), 32'd1);
        @(negedge clk);
        chk("flush_offer_no_resolve", 32'(bus.o_Resolve_Valid), 32'd0);

        // Flush during EVAL suppresses the misaligned pulse.
        offer(tbl[3]);
        @(negedge clk); bus.i_Branch_Valid = 1'b0; bus.i_Flush = 1'b1;
        @(negedge clk); bus.i_Flush = 1'b0;
        chk("flush_eval_mis", 32'(bus.o_Misaligned), 32'd0);
        chk("flush_eval_resolve", 32'(bus.o_Resolve_Valid), 32'd0);
        chk("flush_eval_ready", 32'(bus.o_Branch_Ready), 32'd1);

`ifdef BRANCH_RESOLVER_STATS_EN
        chk("stat_branches", branch_count, 32'(exp_branches));
        chk("stat_mispredicts", mispredict_count, 32'(exp_mispredicts));
`endif

        // Reset in the middle of EVAL.
        offer(tbl[0]);
        @(negedge clk); bus.i_Branch_Valid = 1'b0;
        chk("rst_mid_pre", 32'(bus.o_Cmp_Enable), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cmp_en", 32'(bus.o_Cmp_Enable), 32'd0);
        chk("rst_mid_cmp_a", bus.o_Cmp_A, 32'd0);
        chk("rst_mid_ready", 32'(bus.o_Branch_Ready), 32'd1);
        @(negedge clk);
        chk("rst_mid_resolve", 32'(bus.o_Resolve_Valid), 32'd0);
        chk("rst_mid_redir", 32'(bus.o_Redirect_Valid), 32'd0);
        rst_n = 1'b1;
        exp_branches = 0;
        exp_mispredicts = 0;
        @(negedge clk);
        run(tbl[2], 1, "post_rst");
        run(tbl[1], 0, "post_rst2");

`ifdef BRANCH_RESOLVER_STATS_EN
        chk("stat_post_rst_branches", branch_count, 32'(exp_branches));
        chk("stat_post_rst_mispredicts", mispredict_count, 32'(exp_mispredicts));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
